// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame constants,
// common command bytes and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_state_e;

   localparam int unsigned PS2_FRAME_FALLS = 11;
   localparam int unsigned PS2_MAX_RETRY   = 2;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for a raw PS/2 line plus a falling-edge strobe on
// the synchronised value. Lines idle high, so all flops reset to 1.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic synced,
   output logic fall_c
);

   logic meta;
   logic prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta   <= 1'b1;
         synced <= 1'b1;
         prev   <= 1'b1;
      end else begin
         meta   <= line;
         synced <= meta;
         prev   <= synced;
      end
   end

   assign fall_c = prev & ~synced;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain pull-low enables.
// Define PS2_TX_RESEND_EN to retry failed frames up to PS2_MAX_RETRY times.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       kbclk,
   input  logic       kb,
   output logic       kbclk_oe,
   output logic       kb_oe
);
   import ps2_pkg::*;

   localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   ps2_state_e       state, state_nxt;
   logic [INH_W-1:0] inh_cnt, inh_nxt;
   logic [TO_W-1:0]  to_cnt, to_nxt;
   logic [3:0]       bit_cnt, bit_nxt;
   logic [7:0]       data_q, data_nxt;
   logic             par_q, par_nxt;
   logic             nack_q, nack_nxt;
   logic             ready_nxt, done_nxt, err_nxt, kbclk_oe_nxt, kb_oe_nxt;
   logic             fail, running, retry_ok_c;
   logic             kbclk_sync, kbclk_fall_c;
   logic             kb_meta, kb_sync;
   logic [15:0]      frame_c;

   ps2_line_sync u_kbclk_sync (
      .clk    (clk),
      .rst    (rst),
      .line   (kbclk),
      .synced (kbclk_sync),
      .fall_c (kbclk_fall_c)
   );

   // The data line only needs synchronising; its edges are never used.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         kb_meta <= 1'b1;
         kb_sync <= 1'b1;
      end else begin
         kb_meta <= kb;
         kb_sync <= kb_meta;
      end
   end

   // Bit presented after fall n+1: data LSB first, parity, then stop (released).
   assign frame_c = {6'h3F, 1'b1, par_q, data_q};

`ifdef PS2_TX_RESEND_EN
   logic [1:0] retry_cnt;

   assign retry_ok_c = (retry_cnt < 2'(PS2_MAX_RETRY));

   // Any entry into INHIBIT from outside IDLE is a retry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retry_cnt <= '0;
      end else if (state == IDLE) begin
         retry_cnt <= '0;
      end else if ((state_nxt == INHIBIT) && (state != INHIBIT)) begin
         retry_cnt <= retry_cnt + 2'd1;
      end
   end
`else
   assign retry_ok_c = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      inh_nxt   = inh_cnt;
      bit_nxt   = bit_cnt;
      data_nxt  = data_q;
      par_nxt   = par_q;
      nack_nxt  = nack_q;
      kb_oe_nxt = kb_oe;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      fail      = 1'b0;
      running   = state inside {REQ, SHIFT, ACK, WAIT_IDLE};

      case (state)
         IDLE: begin
            inh_nxt = '0;
            if (tx_valid && tx_ready) begin
               data_nxt  = tx_data;
               par_nxt   = odd_parity(tx_data);
               state_nxt = INHIBIT;
            end
         end
         INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
               bit_nxt   = '0;
               state_nxt = REQ;
            end else begin
               inh_nxt = inh_cnt + INH_W'(1);
            end
         end
         REQ, SHIFT: begin
            if (kbclk_fall_c) begin
               bit_nxt   = bit_cnt + 4'd1;
               kb_oe_nxt = ~frame_c[bit_cnt];
               state_nxt = (bit_cnt == 4'd9) ? ACK : SHIFT;
            end else if (to_cnt == TO_LAST) begin
               fail = 1'b1;
            end
         end
         ACK: begin
            if (kbclk_fall_c) begin
               nack_nxt  = kb_sync;
               bit_nxt   = 4'(PS2_FRAME_FALLS);
               state_nxt = WAIT_IDLE;
            end else if (to_cnt == TO_LAST) begin
               fail = 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (kbclk_sync && kb_sync) begin
               if (nack_q) begin
                  fail = 1'b1;
               end else begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (to_cnt == TO_LAST) begin
               fail = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (fail) begin
         if (retry_ok_c) begin
            state_nxt = INHIBIT;
            inh_nxt   = '0;
         end else begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
         end
      end

      // Line enables follow the state being entered; data leads the clock release by one cycle.
      kbclk_oe_nxt = (state_nxt == INHIBIT);
      if (state_nxt == INHIBIT) begin
         kb_oe_nxt = (inh_nxt == INH_LAST);
      end else if (state_nxt == REQ) begin
         kb_oe_nxt = 1'b1;
      end else if (state_nxt == IDLE) begin
         kb_oe_nxt = 1'b0;
      end
      ready_nxt = (state_nxt == IDLE);

      if (kbclk_fall_c || (state_nxt != state)) begin
         to_nxt = '0;
      end else if (running && (to_cnt != TO_LAST)) begin
         to_nxt = to_cnt + TO_W'(1);
      end else begin
         to_nxt = to_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         inh_cnt  <= '0;
         to_cnt   <= '0;
         bit_cnt  <= '0;
         data_q   <= '0;
         par_q    <= 1'b0;
         nack_q   <= 1'b0;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
         tx_err   <= 1'b0;
         kbclk_oe <= 1'b0;
         kb_oe    <= 1'b0;
      end else begin
         state    <= state_nxt;
         inh_cnt  <= inh_nxt;
         to_cnt   <= to_nxt;
         bit_cnt  <= bit_nxt;
         data_q   <= data_nxt;
         par_q    <= par_nxt;
         nack_q   <= nack_nxt;
         tx_ready <= ready_nxt;
         tx_done  <= done_nxt;
         tx_err   <= err_nxt;
         kbclk_oe <= kbclk_oe_nxt;
         kb_oe    <= kb_oe_nxt;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model samples each frame,
// and outcomes are compared against a table plus a randomised reference model.
module tb_ps2_host_tx;

   localparam int unsigned INH = 20;
   localparam int unsigned TMO = 500;
   localparam int          H   = 30;
`ifdef PS2_TX_RESEND_EN
   localparam int FAIL_FRAMES = 3;
`else
   localparam int FAIL_FRAMES = 1;
`endif

   typedef struct {
      logic [7:0] data;
      logic       ack_low;
      int         nfalls;
      logic       exp_par;
      logic       exp_done;
      logic       exp_err;
      logic       poke;
   } vec_t;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready, tx_done, tx_err;
   logic       kbclk_oe, kb_oe;
   logic       dev_clk_low, dev_kb_low;
   wire        kbclk;
   wire        kb;

   assign kbclk = ~(kbclk_oe | dev_clk_low);
   assign kb    = ~(kb_oe | dev_kb_low);

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_fall_cyc = 0;
   int err_cyc = 0;
   int dev_req_seen = 0;
   logic [10:0] dev_q[$];
   int mon_inh, mon_overlap, mon_done, mon_err, mon_both, mon_ready;
   bit mon_term;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_done  (tx_done),
      .tx_err   (tx_err),
      .kbclk    (kbclk),
      .kb       (kb),
      .kbclk_oe (kbclk_oe),
      .kb_oe    (kb_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Device side of one frame: wait for the request, clock nfalls falls,
   // sample the line while the clock is high and drive the ack bit on fall 11.
   task automatic dev_frame(input logic ack_low, input int nfalls);
      logic [10:0] bits;
      int w;
      bits = '0;
      w = 0;
      while (!(kbclk_oe == 1'b0 && kb_oe == 1'b1) && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w < 3000) begin
         dev_req_seen++;
         for (int k = 0; k < nfalls; k++) begin
            repeat (H) @(negedge clk);
            bits[k] = kb;
            if (k == 10) begin
               dev_kb_low = ack_low;
               repeat (4) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            last_fall_cyc = cyc;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 10) begin
               repeat (H) @(negedge clk);
               dev_kb_low = 1'b0;
            end
         end
         dev_q.push_back(bits);
      end
   endtask

   task automatic monitor();
      bit seen_hi, inh_over;
      int left;
      seen_hi = 0; inh_over = 0; left = 0;
      mon_inh = 0; mon_overlap = 0; mon_done = 0; mon_err = 0;
      mon_both = 0; mon_ready = 0; mon_term = 0;
      for (int i = 0; i < 30000; i++) begin
         if (!inh_over) begin
            if (kbclk_oe) begin
               mon_inh++;
               seen_hi = 1;
               if (kb_oe) mon_overlap++;
            end else if (seen_hi) begin
               inh_over = 1;
            end
         end
         if (tx_done) mon_done++;
         if (tx_err) mon_err++;
         if (tx_done && tx_err) mon_both++;
         if (!mon_term && (tx_done || tx_err)) begin
            if (tx_err) err_cyc = cyc;
            mon_term = 1;
            left = 5;
         end else if (!mon_term && tx_ready) begin
            mon_ready++;
         end
         if (mon_term) begin
            if (left == 0) break;
            left--;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int frames;
      logic [10:0] exp_frame;
      frames = v.exp_done ? 1 : FAIL_FRAMES;
      exp_frame = {1'b1, v.exp_par, v.data, 1'b0};
      dev_q.delete();
      dev_req_seen = 0;
      @(negedge clk);
      tx_data = v.data;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      fork
         for (int f = 0; f < frames; f++) dev_frame(v.ack_low, v.nfalls);
         monitor();
         if (v.poke) begin
            repeat (200) @(negedge clk);
            check("ready_busy_poke", 32'(tx_ready), 0);
            tx_data = ~v.data;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      check("terminal_seen", 32'(mon_term), 1);
      check("inhibit_len", mon_inh, 32'(INH));
      check("kb_lead", mon_overlap, 1);
      check("frames", dev_req_seen, frames);
      if (v.nfalls == 11) begin
         foreach (dev_q[i]) check("frame_bits", 32'(dev_q[i]), 32'(exp_frame));
      end else begin
         check_range("timeout_delay", err_cyc - last_fall_cyc, 495, 510);
      end
      check("done_pulses", mon_done, 32'(v.exp_done));
      check("err_pulses", mon_err, 32'(v.exp_err));
      check("done_err_same", mon_both, 0);
      check("ready_while_busy", mon_ready, 0);
      check("lines_released", 32'({kbclk_oe, kb_oe}), 0);
      check("ready_after", 32'(tx_ready), 1);
   endtask

   vec_t vecs[5];

   initial begin
      vecs[0] = '{data:8'hED, ack_low:1'b1, nfalls:11, exp_par:1'b1, exp_done:1'b1, exp_err:1'b0, poke:1'b0};
      vecs[1] = '{data:8'hF4, ack_low:1'b1, nfalls:11, exp_par:1'b0, exp_done:1'b1, exp_err:1'b0, poke:1'b1};
      vecs[2] = '{data:8'h00, ack_low:1'b1, nfalls:11, exp_par:1'b1, exp_done:1'b1, exp_err:1'b0, poke:1'b0};
      vecs[3] = '{data:8'hFF, ack_low:1'b0, nfalls:11, exp_par:1'b1, exp_done:1'b0, exp_err:1'b1, poke:1'b0};
      vecs[4] = '{data:8'h5A, ack_low:1'b1, nfalls:4,  exp_par:1'b1, exp_done:1'b0, exp_err:1'b1, poke:1'b0};

      rst = 1'b0;
      tx_data = 8'h00;
      tx_valid = 1'b0;
      dev_clk_low = 1'b0;
      dev_kb_low = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(tx_ready), 1);
      check("rst_done", 32'(tx_done), 0);
      check("rst_err", 32'(tx_err), 0);
      check("rst_kbclk_oe", 32'(kbclk_oe), 0);
      check("rst_kb_oe", 32'(kb_oe), 0);

      for (int i = 0; i < 5; i++) run_txn(vecs[i]);

      // Random bytes against the frame/parity rules.
      for (int r = 0; r < 6; r++) begin
         vec_t v;
         v.data     = 8'($urandom);
         v.ack_low  = ($urandom_range(0, 3) != 0);
         v.nfalls   = 11;
         v.exp_par  = (($countones(v.data) % 2) == 0);
         v.exp_done = v.ack_low;
         v.exp_err  = !v.ack_low;
         v.poke     = 1'b0;
         run_txn(v);
      end

      // Reset while the clock line is inhibited.
      @(negedge clk);
      tx_data = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("inhibit_active", 32'(kbclk_oe), 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_kbclk", 32'(kbclk_oe), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_back_idle", 32'(tx_ready), 1);

      // Reset while data bit 5 is being presented.
      @(negedge clk);
      tx_data = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      dev_q.delete();
      dev_frame(1'b1, 6);
      check("bit5_driven", 32'(kb_oe), 1);
      #2 rst = 1'b0;
      #1;
      check("rst_async_kb", 32'({kbclk_oe, kb_oe}), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      run_txn('{data:8'hFF, ack_low:1'b1, nfalls:11, exp_par:1'b1, exp_done:1'b1, exp_err:1'b0, poke:1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
